// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, mux selects, state enum, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'd20;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SUBI  = 6'd9;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_TRAP      = 4'd13
    } state_t;

    // Datapath control bundle produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_J: known = 1'b1;
            default:                                                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational control decoder: {state, op, mem_ready} -> datapath control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: mem_ready gates the FETCH IR/PC loads and the MEM_WRITE completion pulse.
// Ports: state (current FSM state), op (opcode seen in this state), mem_ready, ctrl (control outputs).
// Macro MULTICYCLE_ILLEGAL_TRAP_EN: TRAP drives illegal; otherwise unknown opcodes complete in DECODE.
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 load only in the cycle memory returns the word
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
                // Unknown opcode retires here as a NOP
                ctrl.instr_done = !is_known_op(op);
`endif
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
            end
            ST_I_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
`endif
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback on a shared datapath.
// Latency: lw 5, R/addi/subi/sw 4, beq/j 3 cycles with zero memory wait; +1 per mem_ready=0 cycle.
// Backpressure: FETCH/MEM_READ/MEM_WRITE stall on mem_ready; optional MEM_TIMEOUT aborts to IDLE with sticky mem_err.
// Ports: clk, rst_n (async active-low), run, op, mem_ready in; datapath selects/enables,
//        instr_done, mem_err, illegal, state_o out.
// Macro MULTICYCLE_ILLEGAL_TRAP_EN: unknown opcodes freeze in TRAP with illegal=1.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0  // 0 disables; must be <= 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       mem_err,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);

    state_t     state_q,    state_d;
    logic [5:0] op_q,       op_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q,  mem_err_d;

    logic       is_wait;
    logic       tmo_hit;
    logic [5:0] op_cur;
    state_t     done_next;
    ctrl_t      ctrl;

    // IR holds the new opcode during DECODE only; afterwards the latched copy is authoritative
    assign op_cur    = (state_q == ST_DECODE) ? op : op_q;
    assign done_next = run ? ST_FETCH : ST_IDLE;

    assign is_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) || (state_q == ST_MEM_WRITE);
    // Abort in the cycle the counter would reach the limit; mem_ready in that cycle still wins
    assign tmo_hit = (TMO_LIMIT != 9'd0) && is_wait && !mem_ready &&
                     (({1'b0, wait_cnt_q} + 9'd1) == TMO_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (run) state_d = ST_FETCH;
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
                          else if (tmo_hit) state_d = ST_IDLE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                    OP_RTYPE:         state_d = ST_R_EXEC;
                    OP_ADDI, OP_SUBI: state_d = ST_I_EXEC;
                    OP_BEQ:           state_d = ST_BRANCH;
                    OP_J:             state_d = ST_JUMP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:          state_d = ST_TRAP;
`else
                    default:          state_d = done_next;
`endif
                endcase
            end
            ST_MEM_ADDR:  state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
                          else if (tmo_hit) state_d = ST_IDLE;
            ST_MEM_WB:    state_d = done_next;
            ST_MEM_WRITE: if (mem_ready) state_d = done_next;
                          else if (tmo_hit) state_d = ST_IDLE;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = done_next;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_I_WB:      state_d = done_next;
            ST_BRANCH:    state_d = done_next;
            ST_JUMP:      state_d = done_next;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d       = (state_q == ST_DECODE) ? op : op_q;
        mem_err_d  = mem_err_q | tmo_hit;
        wait_cnt_d = wait_cnt_q;
        // Clear on every state change so each access starts its own count
        if (!is_wait || (state_d != state_q)) begin
            wait_cnt_d = 8'd0;
        end else if (!mem_ready && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 6'd0;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state     (state_q),
        .op        (op_cur),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign instr_done    = ctrl.instr_done;
    assign illegal       = ctrl.illegal;
    assign mem_err       = mem_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4): reset, R/lw/sw/I/beq/j sequences, timeout, unknown opcode.
// Latency: n/a.
// Backpressure: mem_ready driven per scenario.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       alu_src_a, reg_write, reg_dst, instr_done, mem_err, illegal;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    // Every control output except mem_err, illegal in bit 0
    wire [17:0] ctl_vec = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                           mem_to_reg, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, instr_done, illegal};

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .op            (op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .instr_done    (instr_done),
        .mem_err       (mem_err),
        .illegal       (illegal),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++;
        if (ctl_vec !== 18'd0 || mem_err !== 1'b0) begin
            bad++; $display("FAIL reset_outs got=%h err=%b exp=0", ctl_vec, mem_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", state_o); end
    endtask

    task automatic test_rtype();
        int dones = 0;
        run = 1'b1; op = 6'd20; mem_ready = 1'b1;
        tick();  // FETCH
        dones += int'(instr_done);
        total++;
        if (state_o !== 4'd1 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01) begin
            bad++; $display("FAIL r_fetch st=%0d rd=%b irw=%b pcw=%b srcb=%b exp st=1 1 1 1 01",
                            state_o, mem_read, ir_write, pc_write, alu_src_b);
        end
        tick();  // DECODE
        dones += int'(instr_done);
        total++;
        if (state_o !== 4'd2 || alu_src_b !== 2'b11 || alu_src_a !== 1'b0) begin
            bad++; $display("FAIL r_decode st=%0d srcb=%b srca=%b exp 2 11 0", state_o, alu_src_b, alu_src_a);
        end
        tick();  // R_EXEC
        dones += int'(instr_done);
        total++;
        if (state_o !== 4'd7 || alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
            bad++; $display("FAIL r_exec st=%0d aluop=%b srca=%b srcb=%b exp 7 10 1 00", state_o, alu_op, alu_src_a, alu_src_b);
        end
        tick();  // R_WB
        dones += int'(instr_done);
        total++;
        if (state_o !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || pc_write !== 1'b0) begin
            bad++; $display("FAIL r_wb st=%0d rw=%b dst=%b m2r=%b pcw=%b exp 8 1 0 0 0",
                            state_o, reg_write, reg_dst, mem_to_reg, pc_write);
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL r_done_count got=%0d exp=1", dones); end
        run = 1'b0;
        tick();
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL r_to_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_lw_wait();
        int cyc = 0;
        int held = 0;
        run = 1'b1; op = 6'd35; mem_ready = 1'b1;
        tick(); cyc++;  // FETCH
        run = 1'b0;     // ignored until the instruction retires
        tick(); cyc++;  // DECODE
        tick(); cyc++;  // MEM_ADDR
        total++;
        if (state_o !== 4'd3 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin
            bad++; $display("FAIL lw_addr st=%0d srca=%b srcb=%b aluop=%b exp 3 1 10 00", state_o, alu_src_a, alu_src_b, alu_op);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); cyc++;
            if (state_o === 4'd4 && mem_read === 1'b1 && iord === 1'b1 && mem_write === 1'b0) held++;
        end
        tick(); cyc++;
        mem_ready = 1'b1;  // lands exactly when the counter would hit the limit
        #1;
        if (state_o === 4'd4 && mem_read === 1'b1 && iord === 1'b1 && mem_write === 1'b0) held++;
        total++;
        if (held !== 4) begin bad++; $display("FAIL lw_read_held got=%0d exp=4", held); end
        tick(); cyc++;  // MEM_WB
        total++;
        if (state_o !== 4'd5 || mem_to_reg !== 1'b1 || reg_dst !== 1'b1 || reg_write !== 1'b1 || instr_done !== 1'b1) begin
            bad++; $display("FAIL lw_wb st=%0d m2r=%b dst=%b rw=%b done=%b exp 5 1 1 1 1",
                            state_o, mem_to_reg, reg_dst, reg_write, instr_done);
        end
        total++;
        if (cyc !== 8 || mem_err !== 1'b0) begin bad++; $display("FAIL lw_cycles got=%0d err=%b exp=8 err=0", cyc, mem_err); end
        tick();
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL lw_to_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_back_to_back();
        int idle_seen = 0;
        run = 1'b1; op = 6'd9; mem_ready = 1'b1;
        tick(); tick();  // FETCH, DECODE
        tick();          // I_EXEC
        total++;
        if (state_o !== 4'd9 || alu_op !== 2'b01 || alu_src_b !== 2'b10) begin
            bad++; $display("FAIL subi_exec st=%0d aluop=%b srcb=%b exp 9 01 10", state_o, alu_op, alu_src_b);
        end
        op = 6'd8;       // next opcode appears early; latched copy must keep subi
        #1;
        total++;
        if (alu_op !== 2'b01) begin bad++; $display("FAIL subi_opq aluop=%b exp=01", alu_op); end
        tick();          // I_WB
        total++;
        if (state_o !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b1 || instr_done !== 1'b1) begin
            bad++; $display("FAIL subi_wb st=%0d rw=%b dst=%b done=%b exp 10 1 1 1", state_o, reg_write, reg_dst, instr_done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();      // FETCH, DECODE, I_EXEC
            if (state_o === 4'd0) idle_seen++;
        end
        total++;
        if (state_o !== 4'd9 || alu_op !== 2'b00 || idle_seen !== 0) begin
            bad++; $display("FAIL addi_exec st=%0d aluop=%b idle=%0d exp 9 00 0", state_o, alu_op, idle_seen);
        end
        run = 1'b0;
        tick(); tick();
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL addi_to_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_branch_jump();
        run = 1'b1; op = 6'd4; mem_ready = 1'b1;
        tick(); tick(); tick();  // FETCH, DECODE, BRANCH
        total++;
        if (state_o !== 4'd11 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 ||
            instr_done !== 1'b1 || pc_write !== 1'b0 || reg_write !== 1'b0) begin
            bad++; $display("FAIL beq st=%0d pwc=%b src=%b aluop=%b done=%b exp 11 1 01 01 1",
                            state_o, pc_write_cond, pc_source, alu_op, instr_done);
        end
        op = 6'd2;
        tick();
        total++;
        if (state_o !== 4'd1) begin bad++; $display("FAIL beq_next got=%0d exp=1", state_o); end
        tick(); tick();          // DECODE, JUMP
        total++;
        if (state_o !== 4'd12 || pc_write !== 1'b1 || pc_source !== 2'b10 || instr_done !== 1'b1 || reg_write !== 1'b0) begin
            bad++; $display("FAIL jump st=%0d pcw=%b src=%b done=%b exp 12 1 10 1", state_o, pc_write, pc_source, instr_done);
        end
        run = 1'b0;
        tick();
        total++;
        if (state_o !== 4'd0) begin bad++; $display("FAIL jump_to_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_sw_reset();
        run = 1'b1; op = 6'd43; mem_ready = 1'b1;
        tick(); run = 1'b0;
        tick(); tick();          // DECODE, MEM_ADDR
        mem_ready = 1'b0;
        tick();                  // MEM_WRITE, stalled
        total++;
        if (state_o !== 4'd6 || mem_write !== 1'b1 || mem_read !== 1'b0 || iord !== 1'b1 || instr_done !== 1'b0) begin
            bad++; $display("FAIL sw_wait st=%0d wr=%b rd=%b iord=%b done=%b exp 6 1 0 1 0",
                            state_o, mem_write, mem_read, iord, instr_done);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (instr_done !== 1'b1) begin bad++; $display("FAIL sw_done got=%b exp=1", instr_done); end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b0 || state_o !== 4'd0 || ctl_vec !== 18'd0) begin
            bad++; $display("FAIL sw_async_reset wr=%b st=%0d vec=%h exp 0 0 0", mem_write, state_o, ctl_vec);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int dones = 0;
        run = 1'b1; op = 6'd20; mem_ready = 1'b0;
        tick();                  // FETCH, first wait cycle
        total++;
        if (state_o !== 4'd1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            bad++; $display("FAIL tmo_fetch st=%0d irw=%b pcw=%b exp 1 0 0", state_o, ir_write, pc_write);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();              // wait cycles 2..4
            dones += int'(instr_done);
        end
        total++;
        if (state_o !== 4'd1 || mem_err !== 1'b0) begin
            bad++; $display("FAIL tmo_before st=%0d err=%b exp 1 0", state_o, mem_err);
        end
        tick();
        dones += int'(instr_done);
        total++;
        if (state_o !== 4'd0 || mem_err !== 1'b1 || dones !== 0) begin
            bad++; $display("FAIL tmo_abort st=%0d err=%b done=%0d exp 0 1 0", state_o, mem_err, dones);
        end
        mem_ready = 1'b1;
        tick(); tick(); tick();
        total++;
        if (mem_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", mem_err); end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", mem_err); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_unknown_op();
        run = 1'b1; op = 6'd63; mem_ready = 1'b1;
        tick(); tick();          // FETCH, DECODE
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        total++;
        if (instr_done !== 1'b0) begin bad++; $display("FAIL trap_decode done=%b exp=0", instr_done); end
        tick(); tick();
        total++;
        if (state_o !== 4'd13 || ctl_vec !== 18'd1) begin
            bad++; $display("FAIL trap_hold st=%0d vec=%h exp 13 00001", state_o, ctl_vec);
        end
`else
        total++;
        if (state_o !== 4'd2 || instr_done !== 1'b1 || illegal !== 1'b0) begin
            bad++; $display("FAIL nop_decode st=%0d done=%b ill=%b exp 2 1 0", state_o, instr_done, illegal);
        end
        tick();
        total++;
        if (state_o !== 4'd1 || illegal !== 1'b0) begin
            bad++; $display("FAIL nop_next st=%0d ill=%b exp 1 0", state_o, illegal);
        end
`endif
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0 || ctl_vec !== 18'd0) begin
            bad++; $display("FAIL unk_reset st=%0d vec=%h exp 0 0", state_o, ctl_vec);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_branch_jump();
        test_sw_reset();
        test_timeout();
        test_unknown_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS main controller: a Moore/Mealy FSM that sequences the shared datapath (one memory port, one ALU, IR, PC, register file) over 3–5 cycles per instruction.
- Sits beside the instruction register. Decodes the same opcode set as the single-cycle decoder and drives the multi-cycle mux selects and write enables.
- Waits on a memory-ready handshake on every memory access.

Parameters:
- MEM_TIMEOUT, 0, max wait cycles per memory access before aborting; 0 disables the timeout. Must be ≤ 255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  allow fetching the next instruction
- op  in  6  opcode field from IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 PC address, 1 ALUOut address
- mem_read  out  1
- mem_write  out  1
- ir_write  out  1
- mem_to_reg  out  1
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- reg_write  out  1
- reg_dst  out  1  0 rd, 1 rt
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- mem_err  out  1  sticky timeout flag, cleared only by reset
- illegal  out  1  only with the optional feature; otherwise tied 0
- state_o  out  4  current state, for debug

Behaviour:
- Async reset (rst_n=0): state=IDLE, latched op_q=0, wait counter=0, mem_err=0. Every output is 0 immediately, including mid-instruction.
- Outputs are decoded from the state. The Mealy exceptions are ir_write and pc_write in FETCH, which equal mem_ready.
- Opcodes: 20 R-type, 35 lw, 43 sw, 8 addi, 9 subi, 4 beq, 2 j.
- op is sampled into op_q in DECODE; later states use only op_q.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Stay until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Branch on op:
  - 35/43 → MEM_ADDR
  - 20 → R_EXEC
  - 8/9 → I_EXEC
  - 4 → BRANCH
  - 2 → JUMP
  - other → see the optional feature
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_dst=1, mem_to_reg=1, reg_write=1, instr_done=1.
- MEM_WRITE: mem_write=1, iord=1. On mem_ready: instr_done=1, then next state.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=00 if op_q=8, 01 if op_q=9. Go to I_WB.
- I_WB: reg_dst=1, reg_write=1, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- After each instr_done state: go to FETCH if run=1, else IDLE. run is ignored mid-instruction.
- Latency with zero wait cycles:
  - lw: 5 cycles
  - R-type, addi, subi, sw: 4 cycles
  - beq, j: 3 cycles
- Wait states (FETCH, MEM_READ, MEM_WRITE):
  - An 8-bit counter clears on state entry and increments per cycle while mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready=0: set mem_err, go to IDLE, no instr_done.
  - If mem_ready=1 in the same cycle the counter reaches the limit, the access completes normally (ready wins).
- mem_read and mem_write are never both 1. reg_write and any PC write are never both 1.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds illegal=1 with all other outputs 0 until reset.
- Undefined: an unknown opcode is a NOP. DECODE pulses instr_done and returns to FETCH/IDLE per run. illegal is tied 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE=20, OP_LW=35, OP_SW=43, OP_ADDI=8, OP_SUBI=9, OP_BEQ=4, OP_J=2)
  - ALUOp encodings and the alu_src_b / pc_source encodings
  - the 4-bit state enum
- One sub-module, multicycle_ctrl_outdec: purely combinational {state, op_q, mem_ready} → control outputs. The parent holds the state register, op_q, the counter and mem_err.

Test Plan:
- Reset, run=1, op=20, mem_ready=1: states IDLE→FETCH→DECODE→R_EXEC→R_WB; reg_write=1, reg_dst=0 in cycle 4; instr_done pulses once.
- op=35, mem_ready low for 3 cycles in MEM_READ: mem_read and iord held for 4 cycles; MEM_WB asserts mem_to_reg=1, reg_dst=1; total 8 cycles.
- op=9 then op=8 back-to-back with run=1: I_EXEC alu_op=01 for the first and 00 for the second; no IDLE between them.
- op=4 then op=2: BRANCH shows pc_write_cond=1, pc_source=01; JUMP shows pc_write=1, pc_source=10; each takes 3 cycles.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: after 4 wait cycles mem_err=1, state IDLE, mem_err stays set until rst_n pulse.
- op=63: with the macro, illegal=1 and state frozen; without it, instr_done pulses in DECODE, then FETCH. rst_n low during MEM_WRITE drops mem_write to 0 that same cycle.
